// File: rtl/regfile_sequencer.sv
// Multi-cycle control sequencer for the two-register 8-bit datapath: fetches an
// instruction, then drives read selects, ALU op, write-back mux and write port.
module regfile_sequencer #(
  parameter int PC_WIDTH      = 8,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [7:0]          imem_data,
  output logic                readReg_1,
  output logic                readReg_2,
  input  logic [7:0]          readData_1,
  input  logic [7:0]          readData_2,
  output logic                alu_op,
  output logic                wb_sel,
  output logic [7:0]          imm_out,
  output logic                regWrite,
  output logic                writeReg,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          dbgState
);

  // Fetch handshake: imem_req stays high for every FETCH cycle; the word on
  // imem_data is taken on the first rising edge where imem_valid is high.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam int CW = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;

  state_t              state, stateN;
  logic [PC_WIDTH-1:0] pc, pcN;
  logic [7:0]          ir, irN;
  logic [CW-1:0]       cnt, cntN;
  logic                errN;

  logic       reqN, sel1N, sel2N, aluN, wbSelN, regWriteN, writeRegN, busyN, doneN;
  logic [7:0] immN;
  logic       isBranchN, inOperandN;

  assign imem_addr = pc;
  assign dbgState  = state;

  always_comb begin
    stateN = state;
    pcN    = pc;
    irN    = ir;
    cntN   = cnt;
    errN   = err;
    unique case (state)
      IDLE, HALT: begin
        if (start) begin
          stateN = FETCH;
          pcN    = '0;
          cntN   = '0;
          errN   = 1'b0;
        end
      end
      FETCH: begin
        // A word arriving in the last allowed cycle still counts as a fetch.
        if (imem_valid) begin
          irN    = imem_data;
          cntN   = '0;
          stateN = DECODE;
        end else if (cnt == CW'(FETCH_TIMEOUT - 1)) begin
          cntN   = '0;
          errN   = 1'b1;
          stateN = HALT;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      DECODE: begin
        stateN = (ir[7:5] == 3'b111) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        if (ir[7:5] == 3'b110) begin
          pcN    = (readData_1 == readData_2) ? pc + PC_WIDTH'(2) : pc + PC_WIDTH'(1);
          stateN = FETCH;
        end else begin
          stateN = WRITEBACK;
        end
      end
      WRITEBACK: begin
        pcN    = pc + PC_WIDTH'(1);
        stateN = FETCH;
      end
      default: stateN = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered with it.
  always_comb begin
    isBranchN  = (irN[7:6] == 2'b11);
    inOperandN = (stateN == DECODE) || (stateN == EXECUTE) || (stateN == WRITEBACK);
    reqN       = (stateN == FETCH);
    busyN      = (stateN == FETCH) || inOperandN;
    doneN      = (stateN == HALT);
    sel1N      = 1'b0;
    sel2N      = 1'b0;
    if (inOperandN) begin
      sel1N = isBranchN ? 1'b0 : irN[4];
      sel2N = isBranchN ? 1'b1 : irN[3];
    end
    aluN      = ((stateN == EXECUTE) || (stateN == WRITEBACK)) && !irN[7] && irN[6];
    regWriteN = (stateN == WRITEBACK);
    writeRegN = (stateN == WRITEBACK) && irN[5];
    wbSelN    = (stateN == WRITEBACK) && irN[7];
    immN      = {{3{irN[4]}}, irN[4:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      imem_req  <= 1'b0;
      readReg_1 <= 1'b0;
      readReg_2 <= 1'b0;
      alu_op    <= 1'b0;
      wb_sel    <= 1'b0;
      imm_out   <= '0;
      regWrite  <= 1'b0;
      writeReg  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateN;
      pc        <= pcN;
      ir        <= irN;
      cnt       <= cntN;
      err       <= errN;
      imem_req  <= reqN;
      readReg_1 <= sel1N;
      readReg_2 <= sel2N;
      alu_op    <= aluN;
      wb_sel    <= wbSelN;
      imm_out   <= immN;
      regWrite  <= regWriteN;
      writeReg  <= writeRegN;
      busy      <= busyN;
      done      <= doneN;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: instruction memory and two-register
// datapath models around the DUT, with a scoreboard of expected register writes.
module tb_regfile_sequencer;
  localparam int FT = 15;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       imem_req, imem_valid;
  logic [7:0] imem_addr, imem_data;
  logic       readReg_1, readReg_2;
  logic [7:0] readData_1, readData_2;
  logic       alu_op, wb_sel, regWrite, writeReg, busy, done, err;
  logic [7:0] imm_out, wbData;
  logic [2:0] dbgState;

  logic [7:0] mem [256];
  logic [7:0] regs [2];
  logic       memEnable, forceValid;
  logic [8:0] exp_q [$];
  int         nAsserts = 0;
  int         nFails   = 0;

  regfile_sequencer #(.PC_WIDTH(8), .FETCH_TIMEOUT(FT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .readReg_1(readReg_1), .readReg_2(readReg_2), .readData_1(readData_1), .readData_2(readData_2),
    .alu_op(alu_op), .wb_sel(wb_sel), .imm_out(imm_out), .regWrite(regWrite), .writeReg(writeReg),
    .busy(busy), .done(done), .err(err), .dbgState(dbgState)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // instruction memory and register-file / ALU models
  assign imem_valid = (memEnable | forceValid) & imem_req;
  assign imem_data  = mem[imem_addr];
  assign readData_1 = regs[readReg_1];
  assign readData_2 = regs[readReg_2];
  assign wbData     = wb_sel ? imm_out : (alu_op ? readData_1 - readData_2 : readData_1 + readData_2);

  always @(posedge clk) if (regWrite === 1'b1) regs[writeReg] <= wbData;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write pulse must match the front of exp_q
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      nAsserts++;
      assert (exp_q.size() > 0) else begin
        nFails++;
        $error("FAIL unexpected_write: observed wr=%0d data=%h expected no write", writeReg, wbData);
      end
      if (exp_q.size() > 0) chk("write_back", 16'({writeReg, wbData}), 16'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;
  endtask

  task automatic runToDone(input string tag, input int budget);
    int n;
    n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 16'(done), 16'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; memEnable = 1'b0; forceValid = 1'b0;
    clearMem();
    repeat (2) tick();

    // reset state
    chk("reset_ctrl", 16'({imem_req, readReg_1, readReg_2, alu_op, wb_sel, regWrite, writeReg}), 16'd0);
    chk("reset_status", 16'({busy, done, err}), 16'd0);
    chk("reset_addr", 16'(imem_addr), 16'd0);
    chk("reset_imm", 16'(imm_out), 16'd0);
    chk("reset_state", 16'(dbgState), 16'd0);

    // start with no instruction available, then fetch timeout
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fetch_req", 16'(imem_req), 16'd1);
    chk("fetch_addr", 16'(imem_addr), 16'd0);
    chk("fetch_busy", 16'(busy), 16'd1);
    n = 1;
    while (imem_req === 1'b1 && n < 100) begin
      tick();
      if (imem_req === 1'b1) n++;
    end
    chk("timeout_cycles", 16'(n), 16'(FT));
    chk("timeout_done", 16'({done, busy}), 16'b10);
    chk("timeout_err", 16'(err), 16'd1);
    chk("timeout_state", 16'(dbgState), 16'd5);

    // valid in the cycle the timeout would fire wins
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_err_clr", 16'(err), 16'd0);
    repeat (FT - 1) tick();
    chk("last_fetch_cycle", 16'(dbgState), 16'd1);
    forceValid = 1'b1;
    tick();
    forceValid = 1'b0;
    chk("late_valid_decode", 16'(dbgState), 16'd2);
    tick();
    chk("late_valid_halt", 16'({done, err}), 16'b10);

    // LI $s0,-1 ; LI $s1,3 ; ADD $s0=$s1+$s1 ; HALT
    mem[0] = 8'h9F; mem[1] = 8'hA3; mem[2] = 8'h18; mem[3] = 8'hE0;
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b1, 8'h03});
    exp_q.push_back({1'b0, 8'h06});
    memEnable = 1'b1;
    start = 1'b1;
    tick();
    chk("prog_first_fetch", 16'(dbgState), 16'd1);
    tick();
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("prog_latency_busy", 16'({busy, dbgState}), 16'({1'b1, 3'd2}));
    tick();
    chk("prog_done", 16'({done, busy, err}), 16'b100);
    chk("prog_pc", 16'(imem_addr), 16'd3);
    chk("prog_writes_all", 16'(exp_q.size()), 16'd0);

    // reset while in WRITEBACK
    exp_q.push_back({1'b0, 8'hFF});
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("wb_state", 16'({regWrite, dbgState}), 16'({1'b1, 3'd4}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("wb_reset_write", 16'(regWrite), 16'd0);
    chk("wb_reset_state", 16'({busy, dbgState}), 16'd0);
    chk("wb_reset_pc", 16'(imem_addr), 16'd0);

    // BEQ taken: $s0 == $s1 == 5, skip lands on pc 6
    clearMem();
    mem[0] = 8'h85; mem[1] = 8'hA5; mem[2] = 8'h85; mem[3] = 8'hA5; mem[4] = 8'hC0;
    mem[5] = 8'h80;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 8'h05});
      exp_q.push_back({1'b1, 8'h05});
    end
    runToDone("beq_eq_done", 80);
    chk("beq_eq_pc", 16'(imem_addr), 16'd6);

    // BEQ not taken: $s0=5, $s1=4
    clearMem();
    mem[0] = 8'h85; mem[1] = 8'hA4; mem[2] = 8'h85; mem[3] = 8'hA4; mem[4] = 8'hC0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, 8'h05});
      exp_q.push_back({1'b1, 8'h04});
    end
    runToDone("beq_ne_done", 80);
    chk("beq_ne_pc", 16'(imem_addr), 16'd5);
    chk("beq_writes_all", 16'(exp_q.size()), 16'd0);

    // pc wrap: untaken BEQs up to 0xFE, LI at 0xFF, next fetch at 0x00
    for (int i = 0; i < 255; i++) mem[i] = 8'hC0;
    mem[255] = 8'hA2;
    exp_q.push_back({1'b1, 8'h02});
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (regWrite !== 1'b1 && n < 1200) begin
      tick();
      n++;
    end
    chk("wrap_reached", 16'(regWrite), 16'd1);
    chk("wrap_pc_ff", 16'(imem_addr), 16'h00FF);
    tick();
    chk("wrap_pc_00", 16'({imem_req, imem_addr}), 16'h0100);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("final_writes_all", 16'(exp_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
